// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids, latched request control.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_e;

  typedef enum logic {
    REQ_CORE,
    REQ_DBG
  } req_id_e;

  // Control half of an accepted request; address/data travel straight to the mem_* registers.
  typedef struct packed {
    req_id_e id;
    logic    we;
    logic    err;
  } req_ctl_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick: bit0 = core, bit1 = debug; tie goes to the port that did not win last.
// Purely combinational; lock pins the grant to debug (core starves while lock is high).
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_e    last_grant,
  input  logic       lock,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (lock) begin
      grant[1] = valid[1];
    end else if (&valid) begin
      if (last_grant == REQ_DBG) grant[0] = 1'b1;
      else                       grant[1] = 1'b1;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port data_mem between core LSU and debug port; 3-cycle access (accept, issue, respond).
// Ready only in IDLE, responses have no back-pressure; DMEM_ARB_LOCK_EN enables debug grant locking.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  localparam int MW     = DATA_W / 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic              core_req_we,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic [DATA_W-1:0] core_req_wdata,
  input  logic [MW-1:0]     core_req_mask,
  output logic              core_rsp_valid,
  output logic [DATA_W-1:0] core_rsp_rdata,
  output logic              core_rsp_err,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_we,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  input  logic [MW-1:0]     dbg_req_mask,
  output logic              dbg_rsp_valid,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic              dbg_rsp_err,
  input  logic              dbg_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MW-1:0]     mem_mask,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state;
  req_id_e           last_grant;
  req_id_e           win_id;
  req_ctl_t          ctl;
  logic [1:0]        grant;
  logic              lock;
  logic              idle;
  logic [ADDR_W-3:0] req_idx;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic [MW-1:0]     req_mask;
  logic              req_err;
  logic              unused_ok;

`ifdef DMEM_ARB_LOCK_EN
  assign lock = dbg_lock && (last_grant == REQ_DBG);
`else
  assign lock = 1'b0;
`endif

  // Byte offset is dropped on purpose: accesses are word-wide with byte enables.
  assign unused_ok = ^{core_req_addr[1:0], dbg_req_addr[1:0], dbg_lock};

  dmem_rr_pick u_pick (
    .valid      ({dbg_req_valid, core_req_valid}),
    .last_grant (last_grant),
    .lock       (lock),
    .grant      (grant)
  );

  assign idle           = (state == IDLE) && !rst;
  assign core_req_ready = idle && grant[0];
  assign dbg_req_ready  = idle && grant[1];
  assign win_id         = grant[1] ? REQ_DBG : REQ_CORE;

  always_comb begin
    req_idx   = core_req_addr[ADDR_W-1:2];
    req_we    = core_req_we;
    req_wdata = core_req_wdata;
    req_mask  = core_req_mask;
    if (grant[1]) begin
      req_idx   = dbg_req_addr[ADDR_W-1:2];
      req_we    = dbg_req_we;
      req_wdata = dbg_req_wdata;
      req_mask  = dbg_req_mask;
    end
  end

  assign req_err = (req_idx >= (ADDR_W-2)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= REQ_DBG;
      ctl            <= '{id: REQ_CORE, we: 1'b0, err: 1'b0};
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_mask       <= '0;
      core_rsp_valid <= 1'b0;
      core_rsp_err   <= 1'b0;
      dbg_rsp_valid  <= 1'b0;
      dbg_rsp_err    <= 1'b0;
    end else begin
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      core_rsp_valid <= 1'b0;
      core_rsp_err   <= 1'b0;
      dbg_rsp_valid  <= 1'b0;
      dbg_rsp_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            ctl        <= '{id: win_id, we: req_we, err: req_err};
            last_grant <= win_id;
            // Out-of-range accesses never touch the memory; they only produce an error response.
            mem_en     <= !req_err;
            mem_we     <= req_we && !req_err;
            mem_addr   <= req_idx[AW-1:0];
            mem_wdata  <= req_wdata;
            mem_mask   <= req_mask;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          core_rsp_valid <= (ctl.id == REQ_CORE);
          core_rsp_err   <= (ctl.id == REQ_CORE) && ctl.err;
          dbg_rsp_valid  <= (ctl.id == REQ_DBG);
          dbg_rsp_err    <= (ctl.id == REQ_DBG) && ctl.err;
          state          <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // mem_rdata lands during RESP, so it is forwarded rather than registered.
  assign core_rsp_rdata = (core_rsp_valid && !ctl.we && !ctl.err) ? mem_rdata : '0;
  assign dbg_rsp_rdata  = (dbg_rsp_valid  && !ctl.we && !ctl.err) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table + scoreboard of expected responses, behavioural data_mem.
module tb_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int MW     = DATA_W / 8;
  localparam int AW     = $clog2(DEPTH);
`ifdef DMEM_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              core_req_valid = 1'b0, core_req_we = 1'b0;
  logic [ADDR_W-1:0] core_req_addr = '0;
  logic [DATA_W-1:0] core_req_wdata = '0;
  logic [MW-1:0]     core_req_mask = '0;
  logic              dbg_req_valid = 1'b0, dbg_req_we = 1'b0, dbg_lock = 1'b0;
  logic [ADDR_W-1:0] dbg_req_addr = '0;
  logic [DATA_W-1:0] dbg_req_wdata = '0;
  logic [MW-1:0]     dbg_req_mask = '0;
  logic              core_req_ready, core_rsp_valid, core_rsp_err;
  logic              dbg_req_ready, dbg_rsp_valid, dbg_rsp_err;
  logic [DATA_W-1:0] core_rsp_rdata, dbg_rsp_rdata;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MW-1:0]     mem_mask;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_we(core_req_we),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata), .core_req_mask(core_req_mask),
    .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata), .core_rsp_err(core_rsp_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_we(dbg_req_we),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata), .dbg_req_mask(dbg_req_mask),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
    .dbg_lock(dbg_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hA500_0000 ^ 32'(i));
  endfunction

  // data_mem: read data valid the cycle after mem_en
  logic [31:0] mem [DEPTH];
  bit          init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we)
        for (int b = 0; b < MW; b++)
          if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          cv;
    bit          cwe;
    logic [31:0] caddr;
    logic [31:0] cwd;
    logic [3:0]  cm;
    bit          dv;
    bit          dwe;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [3:0]  dm;
    bit          lock;
    bit          exp_dbg;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vt[14];
  logic [31:0] shadow [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and score any response visible in that cycle.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      chk("rsp_missing", 64'(cyc), 64'(e.cyc));
    end
    if (core_rsp_valid || dbg_rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", {62'd0, dbg_rsp_valid, core_rsp_valid}, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_port",  64'(dbg_rsp_valid), 64'(e.port));
        chk("rsp_both",  64'(core_rsp_valid && dbg_rsp_valid), 64'd0);
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("rsp_rdata", e.port ? 64'(dbg_rsp_rdata) : 64'(core_rsp_rdata), 64'(e.rdata));
        chk("rsp_err",   e.port ? 64'(dbg_rsp_err) : 64'(core_rsp_err), 64'(e.err));
      end
    end
  endtask

  task automatic drop_reqs();
    core_req_valid = 1'b0;
    dbg_req_valid  = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    bit          we, err;
    logic [31:0] addr, wd, rd;
    logic [3:0]  m;
    int          widx;
    tick();
    core_req_valid = v.cv; core_req_we = v.cwe; core_req_addr = v.caddr;
    core_req_wdata = v.cwd; core_req_mask = v.cm;
    dbg_req_valid  = v.dv; dbg_req_we = v.dwe; dbg_req_addr = v.daddr;
    dbg_req_wdata  = v.dwd; dbg_req_mask = v.dm;
    dbg_lock       = v.lock;
    #1;
    chk("core_ready", 64'(core_req_ready), 64'(!v.exp_dbg));
    chk("dbg_ready",  64'(dbg_req_ready),  64'(v.exp_dbg));
    we   = v.exp_dbg ? v.dwe   : v.cwe;
    addr = v.exp_dbg ? v.daddr : v.caddr;
    wd   = v.exp_dbg ? v.dwd   : v.cwd;
    m    = v.exp_dbg ? v.dm    : v.cm;
    widx = int'(addr >> 2);
    err  = (widx >= DEPTH);
    rd   = 32'h0;
    if (!err && !we) rd = shadow[widx];
    if (!err && we)
      for (int b = 0; b < 4; b++)
        if (m[b]) shadow[widx][8*b +: 8] = wd[8*b +: 8];
    sbq.push_back('{port: v.exp_dbg, rdata: rd, err: err, cyc: cyc + 2});
    tick();
    drop_reqs();
    chk("issue_mem_en", 64'(mem_en), 64'(!err));
    if (!err) begin
      chk("issue_mem_we",   64'(mem_we),   64'(we));
      chk("issue_mem_addr", 64'(mem_addr), 64'(widx));
      chk("issue_mem_mask", 64'(mem_mask), 64'(m));
      if (we) chk("issue_mem_wdata", 64'(mem_wdata), 64'(wd));
    end
    chk("issue_ready", {62'd0, dbg_req_ready, core_req_ready}, 64'd0);
    tick();
    chk("resp_mem_en", 64'(mem_en), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);

    vt[0]  = '{1'b1, 1'b0, 32'h10, '0, 4'hF,  1'b0, 1'b0, '0, '0, '0,  1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, '0, '0, '0,  1'b1, 1'b1, 32'h8, 32'h12345678, 4'b0011,  1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 32'h8, '0, 4'hF,  1'b1, 1'b0, 32'h10, '0, 4'hF,  1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 32'h8, '0, 4'hF,  1'b1, 1'b0, 32'h10, '0, 4'hF,  1'b0, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 32'(4*DEPTH), '0, 4'hF,  1'b1, 1'b0, 32'h14, '0, 4'hF,  1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF,  1'b1, 1'b1, 32'h40010000, 32'h55AA55AA, 4'hF,  1'b0, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 32'h23, 32'hCAFEF00D, 4'b1100,  1'b0, 1'b0, '0, '0, '0,  1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, '0, '0, '0,  1'b1, 1'b0, 32'h20, '0, 4'hF,  1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 32'hFFC, '0, 4'hF,  1'b0, 1'b0, '0, '0, '0,  1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, '0, '0, '0,  1'b1, 1'b0, 32'h0, '0, 4'hF,  1'b1, 1'b1};
    vt[10] = '{1'b1, 1'b0, 32'h10, '0, 4'hF,  1'b1, 1'b0, 32'h4, '0, 4'hF,  1'b1, LOCK_ON};
    vt[11] = '{1'b1, 1'b0, 32'h10, '0, 4'hF,  1'b1, 1'b0, 32'h4, '0, 4'hF,  1'b1, 1'b1};
    vt[12] = '{1'b1, 1'b0, 32'h10, '0, 4'hF,  1'b1, 1'b0, 32'h4, '0, 4'hF,  1'b1, LOCK_ON};
    vt[13] = '{1'b1, 1'b0, 32'h10, '0, 4'hF,  1'b1, 1'b0, 32'h4, '0, 4'hF,  1'b0, !LOCK_ON};

    // Reset state, with both requesters pushing so ready gating is exercised.
    core_req_valid = 1'b1; dbg_req_valid = 1'b1; core_req_addr = 32'h10; dbg_req_addr = 32'h4;
    tick();
    tick();
    chk("rst_ready",    {62'd0, dbg_req_ready, core_req_ready}, 64'd0);
    chk("rst_mem_en",   {62'd0, mem_we, mem_en}, 64'd0);
    chk("rst_rsp",      {62'd0, dbg_rsp_valid, core_rsp_valid}, 64'd0);
    chk("rst_rsp_err",  {62'd0, dbg_rsp_err, core_rsp_err}, 64'd0);
    chk("rst_rdata",    {core_rsp_rdata, dbg_rsp_rdata}, 64'd0);
    drop_reqs();
    rst = 1'b0;

    for (int i = 0; i <= 8; i++) apply(vt[i]);

    // Reset during ISSUE drops the access and restores core-first priority.
    tick();
    core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 32'h10; core_req_mask = 4'hF;
    #1;
    chk("abort_core_ready", 64'(core_req_ready), 64'd1);
    tick();
    drop_reqs();
    chk("abort_issue_mem_en", 64'(mem_en), 64'd1);
    rst = 1'b1;
    tick();
    chk("abort_mem_en", 64'(mem_en), 64'd0);
    chk("abort_rsp", {62'd0, dbg_rsp_valid, core_rsp_valid}, 64'd0);
    core_req_valid = 1'b1; dbg_req_valid = 1'b1;
    dbg_req_we = 1'b0; dbg_req_addr = 32'h4; dbg_req_mask = 4'hF;
    #1;
    chk("abort_rst_ready", {62'd0, dbg_req_ready, core_req_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", {62'd0, dbg_req_ready, core_req_ready}, 64'b01);
    sbq.push_back('{port: 1'b0, rdata: shadow[4], err: 1'b0, cyc: cyc + 2});
    tick();
    drop_reqs();
    tick();
    tick();
    chk("post_rst_idle", {62'd0, dbg_rsp_valid, core_rsp_valid}, 64'd0);

    for (int i = 9; i <= 13; i++) apply(vt[i]);

    tick();
    tick();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
